fsm_stim_player: RTL

//  Drive side of the sw_in/ctrl_in step interface used by our small Moore FSM blocks (e.g. moore2).

---
 rtl/fsm_test_pkg.sv | 25 ++
 rtl/stim_mem.sv | 32 +++
 rtl/fsm_stim_player.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_test_pkg.sv
// Shared types for the FSM stimulus player.
//   player_state_e : sequencer states of fsm_stim_player
//   entry_t        : one sequence entry {sw, exp_out, exp_state}
//   SW_W / ST_W    : switch width driven to the FSM / FSM state width checked
package fsm_test_pkg;

   localparam int SW_W = 2;
   localparam int ST_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_STEP,
      S_CHECK,
      S_WAIT,
      S_DONE
   } player_state_e;

   typedef struct packed {
      logic [SW_W-1:0] sw;
      logic            exp_out;
      logic [ST_W-1:0] exp_state;
   } entry_t;

endpackage

// File: rtl/stim_mem.sv
// Sequence memory: DEPTH x entry_t register array, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset
// so a loaded sequence survives a reset of the player.
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write index
//   wdata  : entry to write
//   raddr  : read index
//   rdata  : entry at raddr (combinational)
module stim_mem
   import fsm_test_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsm_stim_player.sv
// Plays a preloaded sequence of switch values into a small Moore FSM, one
// ctrl_out step pulse per entry, and checks the FSM's registered out/state
// after each step.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | after reset, waiting for start
//   S_DRIVE | setup cycle: sw_out loaded from mem[idx], pulse armed
//   S_STEP  | ctrl_out high for exactly this cycle
//   S_CHECK | compare dut_out/dut_state against mem[idx] expectations
//   S_WAIT  | GAP idle cycles before the next entry
//   S_DONE  | run finished, done high, sw_out holds last value
//
// Ports:
//   clk, reset            : clock, async active-high reset
//   cfg_we/addr/sw/exp_*  : sequence entry write (ignored while busy)
//   seq_len               : entries to play, clamped to DEPTH
//   start                 : begin playback (IDLE/DONE only)
//   sw_out, ctrl_out      : drive to FSM sw_in / ctrl_in
//   dut_out, dut_state    : FSM registered outputs being checked
//   busy, done            : run status
//   err_cnt, err_valid, first_err : mismatch statistics of current run
module fsm_stim_player
   import fsm_test_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int GAP   = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [SW_W-1:0] cfg_sw,
   input  logic            cfg_exp_out,
   input  logic [ST_W-1:0] cfg_exp_state,
   input  logic [AW:0]     seq_len,
   input  logic            start,
   output logic [SW_W-1:0] sw_out,
   output logic            ctrl_out,
   input  logic            dut_out,
   input  logic [ST_W-1:0] dut_state,
   output logic            busy,
   output logic            done,
   output logic [AW:0]     err_cnt,
   output logic            err_valid,
   output logic [AW-1:0]   first_err
);

   localparam int LW     = AW + 1;
   localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

   player_state_e   state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [LW-1:0]   len_q, len_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [SW_W-1:0] sw_q, sw_d;
   logic            ctrl_q, ctrl_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [LW-1:0]   err_cnt_q, err_cnt_d;
   logic            err_valid_q, err_valid_d;
   logic [AW-1:0]   first_err_q, first_err_d;

   entry_t          rd_entry;
   entry_t          wr_entry;
   logic [LW-1:0]   len_clamped;
   logic            next_dec;
   logic            last_entry;

   assign wr_entry = '{sw: cfg_sw, exp_out: cfg_exp_out, exp_state: cfg_exp_state};

   // Memory is frozen for the whole run so the played sequence is stable.
   stim_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (cfg_we && !busy_q),
      .waddr (cfg_addr),
      .wdata (wr_entry),
      .raddr (idx_q),
      .rdata (rd_entry)
   );

   assign len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
   assign last_entry  = ({1'b0, idx_q} == (len_q - LW'(1)));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      gap_d       = gap_q;
      sw_d        = sw_q;
      ctrl_d      = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      err_cnt_d   = err_cnt_q;
      err_valid_d = err_valid_q;
      first_err_d = first_err_q;
      next_dec    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d       = len_clamped;
               err_cnt_d   = '0;
               err_valid_d = 1'b0;
               first_err_d = '0;
               done_d      = 1'b0;
               if (len_clamped == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  state_d = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            sw_d    = rd_entry.sw;
            ctrl_d  = 1'b1;
            state_d = S_STEP;
         end
         S_STEP: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if ((dut_out != rd_entry.exp_out) || (dut_state != rd_entry.exp_state)) begin
               err_cnt_d = err_cnt_q + LW'(1);
               if (!err_valid_q) begin
                  err_valid_d = 1'b1;
                  first_err_d = idx_q;
               end
            end
            if (GAP > 0) begin
               gap_d   = GW'(GAP_M1);
               state_d = S_WAIT;
            end else begin
               next_dec = 1'b1;
            end
         end
         S_WAIT: begin
            if (gap_q == '0) next_dec = 1'b1;
            else             gap_d    = gap_q - GW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      if (next_dec) begin
         if (last_entry) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_DRIVE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         sw_q        <= '0;
         ctrl_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_cnt_q   <= '0;
         err_valid_q <= 1'b0;
         first_err_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         sw_q        <= sw_d;
         ctrl_q      <= ctrl_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_cnt_q   <= err_cnt_d;
         err_valid_q <= err_valid_d;
         first_err_q <= first_err_d;
      end
   end

   assign sw_out    = sw_q;
   assign ctrl_out  = ctrl_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_cnt   = err_cnt_q;
   assign err_valid = err_valid_q;
   assign first_err = first_err_q;

endmodule
